db9_md_reader: RTL and testbench

Polls two Sega Mega Drive 3/6-button pads through the shared DB9 user port and produces active-high joystick words for the core's input mapping. It drives the pad select line (`joy_mdsel`) and the port multiplexer line (`joy_split`), and samples the 6-bit pad bus. It publishes one coherent joystick word per player per scan frame, and flags for pad presence and 6-button type. It sits between the user-port pins and the per-core joystick muxing and OSD logic.

---
 rtl/db9_md_reader.sv | 187 ++++++++++++++++++
 tb/tb_db9_md_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/db9_md_reader.sv
// Polls two Mega Drive 3/6-button pads over the shared DB9 port and publishes
// one coherent active-high joystick word per player per scan frame.
module db9_md_reader #(
  parameter int unsigned TICK_DIV   = 256,
  parameter int unsigned IDLE_TICKS = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_present,
  output logic [1:0]  six_btn
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam int unsigned STEP_W = 4;
  localparam int unsigned BTN_W  = 12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step, step_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_end, idle_last;
  logic                mdsel_nxt, split_nxt;
  logic                capture_c, frame_start_c, frame_done_c;
  logic                pub_pend;
  logic [5:0]          sync1, sync2, pin_n;
  logic                player;
  logic [2:0]          phase;
  logic [1:0][BTN_W-1:0] sh_btn;
  logic [1:0]          sh_present, sh_six;
  logic [1:0][15:0]    pub_word;

  assign tick_end  = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign idle_last = (idle_cnt == IDLE_W'(IDLE_TICKS - 1));
  assign pin_n     = ~sync2;
  assign player    = step[0];
  assign phase     = step[3:1];

  // Two-flop synchronizer for the asynchronous pad pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= joy_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else          tick_cnt <= tick_end ? '0 : tick_cnt + TICK_W'(1);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      step     <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Next state: IDLE for IDLE_TICKS ticks, then 16 ticks of SCAN (8 phases x A/B)
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    idle_nxt  = idle_cnt;
    if (tick_end) begin
      case (state)
        S_IDLE: begin
          if (idle_last) begin
            state_nxt = S_SCAN;
            idle_nxt  = '0;
          end else begin
            idle_nxt  = idle_cnt + IDLE_W'(1);
          end
        end
        S_SCAN: begin
          step_nxt = step + STEP_W'(1);
          if (step == STEP_W'(15)) state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: TH/split levels for the upcoming tick plus capture strobes
  always_comb begin
    mdsel_nxt     = 1'b1;
    split_nxt     = 1'b1;
    capture_c     = 1'b0;
    frame_start_c = 1'b0;
    frame_done_c  = 1'b0;
    if (state_nxt == S_SCAN) begin
      mdsel_nxt = ~step_nxt[1];
      split_nxt = ~step_nxt[0];
    end
    if (tick_end) begin
      if (state == S_IDLE) begin
        frame_start_c = idle_last;
      end else begin
        capture_c    = 1'b1;
        frame_done_c = (step == STEP_W'(15));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_mdsel <= 1'b1;
      joy_split <= 1'b1;
      pub_pend  <= 1'b0;
    end else begin
      joy_mdsel <= mdsel_nxt;
      joy_split <= split_nxt;
      pub_pend  <= frame_done_c;
    end
  end

  // Per-player shadow capture; each field is sampled only in its own phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_btn     <= '0;
      sh_present <= '0;
      sh_six     <= '0;
    end else if (frame_start_c) begin
      sh_btn     <= '0;
      sh_present <= '0;
      sh_six     <= '0;
    end else if (capture_c) begin
      case (phase)
        3'd0: sh_btn[player][5:0] <= {pin_n[5], pin_n[4], pin_n[0], pin_n[1], pin_n[2], pin_n[3]};
        3'd1: begin
          sh_present[player] <= ~sync2[2] & ~sync2[3];
          sh_btn[player][6]  <= pin_n[4];
          sh_btn[player][7]  <= pin_n[5];
        end
        3'd5: sh_six[player] <= (sync2[3:0] == 4'b0000);
        3'd6: begin
          if (sh_six[player])
            sh_btn[player][11:8] <= {pin_n[0], pin_n[1], pin_n[2], pin_n[3]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pub_word = '0;
    for (int i = 0; i < 2; i++) begin
      if (sh_present[i]) begin
        pub_word[i][7:0] = sh_btn[i][7:0];
        if (sh_six[i]) pub_word[i][11:8] = sh_btn[i][11:8];
      end
    end
  end

  // Publish all words and flags together, one cycle after the frame ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick1   <= '0;
      joystick2   <= '0;
      pad_present <= '0;
      six_btn     <= '0;
    end else if (pub_pend) begin
      joystick1   <= pub_word[0];
      joystick2   <= pub_word[1];
      pad_present <= sh_present;
      six_btn     <= sh_six & sh_present;
    end
  end

endmodule

// File: tb/tb_db9_md_reader.sv
// Bench for db9_md_reader: behavioural Mega Drive pads on a muxed port, with a
// scoreboard of expected published frames.
module tb_db9_md_reader;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned IDLE_TICKS = 4;
  localparam int FRAME     = (IDLE_TICKS + 16) * TICK_DIV;
  localparam int FIRST_PUB = FRAME + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  joy_in;
  logic        joy_mdsel, joy_split;
  logic [15:0] joystick1, joystick2;
  logic [1:0]  pad_present, six_btn;

  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [1:0]  pp;
    logic [1:0]  six;
  } exp_t;

  exp_t sb_q[$];
  exp_t held;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   last_pub = 1'b0;

  // Pad kinds: 0 = absent, 1 = 3-button, 2 = 6-button; buttons in joystick bit layout
  int          k1 = 0, k2 = 0;
  logic [11:0] b1 = '0, b2 = '0;
  int          th_cnt = 0;
  int          hi_cnt = 0;
  logic        th_prev = 1'b1;

  db9_md_reader #(.TICK_DIV(TICK_DIV), .IDLE_TICKS(IDLE_TICKS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joy_in      (joy_in),
    .joy_mdsel   (joy_mdsel),
    .joy_split   (joy_split),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .pad_present (pad_present),
    .six_btn     (six_btn)
  );

  always #5 clk = ~clk;

  // Pad pin model: returns active-low {pin9, pin6, pin4, pin3, pin2, pin1}
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic th, input int cnt);
    logic [5:0] p;
    if (kind == 0) return 6'h3F;
    if (th) begin
      if (kind == 2 && cnt == 3) p = {b[5], b[4], b[8], b[9], b[10], b[11]};
      else                       p = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (kind == 2 && cnt == 3)      p = {b[7], b[6], 4'hF};
      else if (kind == 2 && cnt == 4) p = {b[7], b[6], 4'h0};
      else                            p = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~p;
  endfunction

  assign joy_in = joy_split ? pad_pins(k1, b1, joy_mdsel, th_cnt)
                            : pad_pins(k2, b2, joy_mdsel, th_cnt);

  // Pad-side TH low-edge counter with idle timeout
  always @(negedge clk) begin
    th_prev <= joy_mdsel;
    hi_cnt  <= joy_mdsel ? hi_cnt + 1 : 0;
    if (joy_mdsel && hi_cnt >= 10)    th_cnt <= 0;
    else if (th_prev && !joy_mdsel)   th_cnt <= th_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic exp_t model(input int a, input logic [11:0] ba,
                                 input int c, input logic [11:0] bc);
    exp_t e;
    e.j1  = (a == 0) ? 16'h0 : (a == 1) ? {8'h0, ba[7:0]} : {4'h0, ba};
    e.j2  = (c == 0) ? 16'h0 : (c == 1) ? {8'h0, bc[7:0]} : {4'h0, bc};
    e.pp  = {c != 0, a != 0};
    e.six = {c == 2, a == 2};
    return e;
  endfunction

  task automatic drive(input int a, input logic [11:0] ba, input int c, input logic [11:0] bc);
    k1 = a; b1 = ba; k2 = c; b2 = bc;
    sb_q.push_back(model(a, ba, c, bc));
  endtask

  // One clock: check TH/split waveform, then either a publish or a hold
  task automatic step();
    int   m, s;
    logic exp_sel, exp_split;
    exp_t e;
    @(posedge clk);
    #1;
    edge_cnt++;
    m = edge_cnt % FRAME;
    if (m < 16) begin
      exp_sel = 1'b1; exp_split = 1'b1;
    end else begin
      s = (m - 16) / 4;
      exp_sel   = ((s / 2) % 2) == 0;
      exp_split = (s % 2) == 0;
    end
    check("mdsel", 64'(joy_mdsel), 64'(exp_sel));
    check("split", 64'(joy_split), 64'(exp_split));
    last_pub = (edge_cnt >= FIRST_PUB) && ((edge_cnt - FIRST_PUB) % FRAME == 0);
    if (last_pub) begin
      check("sb_avail", 64'(sb_q.size() > 0), 64'(1));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        held = e;
        check("joystick1", 64'(joystick1), 64'(e.j1));
        check("joystick2", 64'(joystick2), 64'(e.j2));
        check("pad_present", 64'(pad_present), 64'(e.pp));
        check("six_btn", 64'(six_btn), 64'(e.six));
      end
    end else begin
      check("hold", 64'({joystick1, joystick2, pad_present, six_btn}), 64'(held));
    end
  endtask

  task automatic run_to_publish();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_pub && n <= FIRST_PUB);
    check("pub_seen", 64'(last_pub), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},   64'(joy_mdsel), 64'(1));
    check({tag, "_split"}, 64'(joy_split), 64'(1));
    check({tag, "_outs"},  64'({joystick1, joystick2, pad_present, six_btn}), 64'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    edge_cnt = 0;
    held     = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    drive(1, 12'h041, 0, 12'h000);        // P1 3-button A+Right, P2 absent
    release_reset();
    run_to_publish();                      // publish exactly 81 edges after release

    drive(0, 12'h000, 2, 12'h980);        // P2 6-button Z+Mode+Start
    run_to_publish();
    drive(0, 12'h000, 0, 12'h000);        // no pads: waveform only
    run_to_publish();
    drive(2, 12'hF5A, 1, 12'h234);        // P1 6-button, P2 3-button with X masked
    run_to_publish();

    drive(1, 12'h080, 2, 12'h000);        // Start held on P1, released during p3
    repeat (40) step();
    b1 = 12'h000;
    run_to_publish();
    drive(1, 12'h000, 2, 12'h000);
    run_to_publish();

    drive(1, 12'h0C3, 2, 12'h611);        // frame to be cut by reset during p4
    repeat (52) step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("in_rst");
    sb_q.delete();
    drive(1, 12'h0C3, 2, 12'h611);
    release_reset();
    run_to_publish();
    drive(0, 12'h000, 1, 12'h0F0);
    run_to_publish();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
